// File: rtl/rr_pkg.sv
// Shared definitions for the register-read stage: opcodes, instruction field
// slices, the bubble encoding, the RR/EX register layout and decode helpers.
package rr_pkg;

  localparam int NREGS = 8;
  localparam logic [15:0] BUBBLE_IR = 16'hF000;

  // Instruction field slices
  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RA_HI = 11;
  localparam int RA_LO = 9;
  localparam int RB_HI = 8;
  localparam int RB_LO = 6;
  localparam int RC_HI = 5;
  localparam int RC_LO = 3;

  // Opcodes
  localparam logic [3:0] OP_ADI  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_NAND = 4'b0010;
  localparam logic [3:0] OP_LLI  = 4'b0011;
  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BLT  = 4'b1001;
  localparam logic [3:0] OP_BLE  = 4'b1010;
  localparam logic [3:0] OP_JAL  = 4'b1100;
  localparam logic [3:0] OP_JLR  = 4'b1101;

  // Contents of the RR/EX pipeline register
  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] pc;
    logic [15:0] pc2;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [15:0] imm;
    logic        valid;
    logic        reg_wr_en;
  } ex_t;

  localparam ex_t EX_BUBBLE = '{ir: BUBBLE_IR, pc: 16'h0, pc2: 16'h0, d1: 16'h0,
                                d2: 16'h0, imm: 16'h0, valid: 1'b0, reg_wr_en: 1'b0};

  // Immediate extension by opcode; opcodes without an immediate give 0
  function automatic logic [15:0] imm_gen(input logic [15:0] ir);
    logic [15:0] imm;
    imm = 16'h0;
    case (ir[OP_HI:OP_LO])
      OP_ADI, OP_LW, OP_SW, OP_BEQ, OP_BLT, OP_BLE: imm = {{10{ir[5]}}, ir[5:0]};
      OP_LLI:                                       imm = {7'h0, ir[8:0]};
      OP_JAL, OP_JLR:                               imm = {{7{ir[8]}}, ir[8:0]};
      default:                                      imm = 16'h0;
    endcase
    return imm;
  endfunction

  // Opcodes that may write a register; conditional ALU forms are settled in EX
  function automatic logic writes_reg(input logic [3:0] op);
    logic wr;
    wr = 1'b0;
    case (op)
      OP_ADI, OP_ADD, OP_NAND, OP_LLI, OP_LW, OP_JAL, OP_JLR: wr = 1'b1;
      default:                                               wr = 1'b0;
    endcase
    return wr;
  endfunction

endpackage

// File: rtl/reg_file_8x16.sv
// 8x16 register file: two asynchronous read ports, one synchronous write port,
// synchronous active-high reset clearing every register.
module reg_file_8x16
  import rr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [2:0]  rd_addr_a,
  output logic [15:0] rd_data_a,
  input  logic [2:0]  rd_addr_b,
  output logic [15:0] rd_data_b
);

  logic [15:0] regs_reg [NREGS];

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      // Each register clears on reset and loads when addressed by the write port
      always_ff @(posedge clk) begin
        if (rst) begin
          regs_reg[gi] <= 16'h0;
        end else if (wr_en && (wr_addr == 3'(gi))) begin
          regs_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  assign rd_data_a = regs_reg[rd_addr_a];
  assign rd_data_b = regs_reg[rd_addr_b];

endmodule

// File: rtl/rr_stage.sv
// Register-read stage: reads the register file, picks forwarded / bypassed /
// file operands, generates the immediate and loads the RR/EX register.
// Optional stall-cycle counter enabled by defining RR_STALL_CNT_EN.
module rr_stage
  import rr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir_in,
  input  logic [15:0] pc_in,
  input  logic [15:0] pc2_in,
  input  logic        valid_in,
  input  logic        flush,
  input  logic        freeze,
  input  logic [15:0] d1_fwd,
  input  logic        d1_fwd_en,
  input  logic [15:0] d2_fwd,
  input  logic        d2_fwd_en,
  input  logic        wb_wr_en,
  input  logic [2:0]  wb_addr,
  input  logic [15:0] wb_data,
  output logic [15:0] ir_rr,
  output logic        hold_upstream,
  output logic [15:0] ir_ex,
  output logic [15:0] pc_ex,
  output logic [15:0] pc2_ex,
  output logic [15:0] d1_ex,
  output logic [15:0] d2_ex,
  output logic [15:0] imm_ex,
  output logic        valid_ex,
  output logic        reg_wr_en_ex,
  output logic [15:0] stall_cnt
);

  logic [2:0]  ra_addr;
  logic [2:0]  rb_addr;
  logic [15:0] rf_a;
  logic [15:0] rf_b;
  logic [15:0] d1_sel;
  logic [15:0] d2_sel;
  ex_t         ex_reg;
  ex_t         ex_next;

  assign ra_addr = ir_in[RA_HI:RA_LO];
  assign rb_addr = ir_in[RB_HI:RB_LO];

  // Invalid slots are shown to the forwarding unit as a never-matching bubble
  assign ir_rr = valid_in ? ir_in : BUBBLE_IR;
  // A flush redirects fetch, so it must not be blocked by a concurrent freeze
  assign hold_upstream = freeze && !flush;

  reg_file_8x16 u_rf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wb_wr_en),
    .wr_addr   (wb_addr),
    .wr_data   (wb_data),
    .rd_addr_a (ra_addr),
    .rd_data_a (rf_a),
    .rd_addr_b (rb_addr),
    .rd_data_b (rf_b)
  );

  // Operand select: forwarding first, then same-cycle writeback, then the file
  always_comb begin
    d1_sel = rf_a;
    d2_sel = rf_b;
    if (d1_fwd_en) begin
      d1_sel = d1_fwd;
    end else if (wb_wr_en && (wb_addr == ra_addr)) begin
      d1_sel = wb_data;
    end
    if (d2_fwd_en) begin
      d2_sel = d2_fwd;
    end else if (wb_wr_en && (wb_addr == rb_addr)) begin
      d2_sel = wb_data;
    end
  end

  // Next RR/EX contents: a bubble unless a live, unfrozen, unflushed instruction
  always_comb begin
    ex_next = EX_BUBBLE;
    if (valid_in && !flush && !freeze) begin
      ex_next.ir        = ir_in;
      ex_next.pc        = pc_in;
      ex_next.pc2       = pc2_in;
      ex_next.d1        = d1_sel;
      ex_next.d2        = d2_sel;
      ex_next.imm       = imm_gen(ir_in);
      ex_next.valid     = 1'b1;
      ex_next.reg_wr_en = writes_reg(ir_in[OP_HI:OP_LO]);
    end
  end

  // RR/EX pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_reg <= EX_BUBBLE;
    end else begin
      ex_reg <= ex_next;
    end
  end

  assign ir_ex        = ex_reg.ir;
  assign pc_ex        = ex_reg.pc;
  assign pc2_ex       = ex_reg.pc2;
  assign d1_ex        = ex_reg.d1;
  assign d2_ex        = ex_reg.d2;
  assign imm_ex       = ex_reg.imm;
  assign valid_ex     = ex_reg.valid;
  assign reg_wr_en_ex = ex_reg.reg_wr_en;

`ifdef RR_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  // Saturating count of cycles in which upstream stages were held
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= 16'h0;
    end else if (hold_upstream && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'h1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = 16'h0;
`endif

endmodule

// File: doc/rr_stage.md
Name: rr_stage

Overview:
- Register-read stage of the 16-bit pipeline; it sits directly upstream of the forwarding unit and consumes that unit's outputs.
- Each cycle it:
  - presents the RR-stage instruction to the forwarding unit;
  - reads the 8x16 register file;
  - selects the forwarded or register-file operands;
  - generates the immediate;
  - loads the RR/EX pipeline register.
- On freeze it inserts a bubble into EX and holds upstream stages. On flush it kills the RR instruction.

Parameters:
- NREGS, 8, number of architectural registers (address width fixed at 3)
- BUBBLE_IR, 16'hF000, IR value carried by an invalid slot (opcode 1111 never matches any forwarding condition)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ir_in  in  16  instruction from IF/RR register
- pc_in  in  16  PC of ir_in
- pc2_in  in  16  PC+2 of ir_in
- valid_in  in  1  ir_in is a real instruction
- flush  in  1  branch/jump redirect; kill RR slot
- freeze  in  1  load-use stall request from forwarding unit
- d1_fwd  in  16  forwarded operand A value
- d1_fwd_en  in  1  use d1_fwd for operand A
- d2_fwd  in  16  forwarded operand B value
- d2_fwd_en  in  1  use d2_fwd for operand B
- wb_wr_en  in  1  writeback enable
- wb_addr  in  3  writeback register
- wb_data  in  16  writeback value
- ir_rr  out  16  to forwarding unit IR_RR: valid_in ? ir_in : BUBBLE_IR (combinational)
- hold_upstream  out  1  freeze && !flush (combinational); holds PC and IF/RR register
- ir_ex  out  16  RR/EX instruction
- pc_ex  out  16  RR/EX PC
- pc2_ex  out  16  RR/EX PC+2
- d1_ex  out  16  operand A (register IR[11:9])
- d2_ex  out  16  operand B (register IR[8:6])
- imm_ex  out  16  extended immediate
- valid_ex  out  1  EX slot valid
- reg_wr_en_ex  out  1  feeds reg_wr_en_EX of forwarding unit
- stall_cnt  out  16  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset (rst=1 at posedge):
  - ir_ex=BUBBLE_IR; pc_ex, pc2_ex, d1_ex, d2_ex and imm_ex = 0; valid_ex=0; reg_wr_en_ex=0; stall_cnt=0.
  - All registers in the file = 0. Reset overrides all other inputs.
- Pipeline register update at each posedge, priority rst > flush > freeze > load:
  - flush=1: load bubble (valid_ex=0, ir_ex=BUBBLE_IR, reg_wr_en_ex=0, data fields 0). hold_upstream=0 even if freeze=1.
  - freeze=1 (no flush): load bubble, hold_upstream=1. The RR instruction is re-presented the next cycle.
  - valid_in=0: load bubble.
  - Otherwise: load ir_in, pc_in, pc2_in, operands, imm and decoded reg_wr_en; valid_ex=1.
- Latency: one cycle from RR to EX.
- Operand select, per operand, in priority order:
  - fwd_en=1 -> fwd value;
  - else wb_wr_en=1 and wb_addr matches the source field -> wb_data (write-first bypass);
  - else register-file read.
- Register file: write at posedge when wb_wr_en=1 and rst=0. The write proceeds during freeze and flush.
- reg_wr_en decode: 1 for opcodes 0000, 0001, 0010, 0011, 0100, 1100, 1101; 0 otherwise. Conditional ADD/NAND variants are resolved in EX, not here.
- Immediate:
  - 0000, 0100, 0101, 1000, 1001, 1010 -> sign-extend IR[5:0];
  - 0011 -> zero-extend IR[8:0];
  - 1100, 1101 -> sign-extend IR[8:0];
  - others -> 0.
- Consecutive freezes: a bubble is loaded every frozen cycle. No limit is applied.

Optional Feature:
- Macro: RR_STALL_CNT_EN.
- Defined: stall_cnt increments on every cycle with hold_upstream=1. It saturates at 16'hFFFF and clears only on rst.
- Undefined: stall_cnt is tied to 0 and no counter logic is present.

Decomposition:
- rr_pkg holds:
  - opcode constants;
  - BUBBLE_IR;
  - field-slice localparams (RA=11:9, RB=8:6, RC=5:3);
  - function imm_gen(ir);
  - function writes_reg(opcode).
- One sub-module, reg_file_8x16: two async read ports, one sync write port, sync reset.

Test Plan:
- Reset -> valid_ex=0, ir_ex=16'hF000, d1_ex=d2_ex=0, stall_cnt=0.
- WB R3=16'h1234 one cycle, then ADD ir_in=16'h1708, no forwarding -> next cycle d1_ex=16'h1234, d2_ex=0, reg_wr_en_ex=1, valid_ex=1.
- Same ADD with d1_fwd_en=1, d1_fwd=16'hBEEF, and wb_wr_en=1, wb_addr=3, wb_data=16'h5555 in the same cycle -> d1_ex=16'hBEEF. Repeat with d1_fwd_en=0 -> d1_ex=16'h5555.
- freeze=1 for one cycle with valid ADD -> hold_upstream=1 that cycle, next valid_ex=0 with ir_ex=16'hF000. Following cycle freeze=0 -> ADD in EX. With macro defined, stall_cnt=1.
- flush=1 and freeze=1 together -> hold_upstream=0, next valid_ex=0, reg_wr_en_ex=0.
- ADI ir_in=16'h02BF -> imm_ex=16'hFFFF. LLI ir_in=16'h3BFF -> imm_ex=16'h01FF.
